// File: rtl/snake_body_engine_if.sv
// Snake shift / segment-stream interface between the body engine and the
// playfield renderer.
//   move_enable, move, grow, shift : control into the engine
//   x_out, y_out, exists           : streamed segment, head first
//   end_shift                      : one-cycle pulse after the last segment
//   game_over                      : sticky collision flag
//   snake_head                     : current head, packed {y,x}
// master = engine (producer), slave = renderer / controller side.
interface snake_body_engine_if #(
  parameter int H = 32,
  parameter int V = 32
);
  localparam int X_BITS = $clog2(H);
  localparam int Y_BITS = $clog2(V);

  logic                       move_enable;
  logic [1:0]                 move;
  logic                       grow;
  logic                       shift;
  logic [X_BITS-1:0]          x_out;
  logic [Y_BITS-1:0]          y_out;
  logic                       exists;
  logic                       game_over;
  logic                       end_shift;
  logic [X_BITS+Y_BITS-1:0]   snake_head;

  modport master (
    input  move_enable, move, grow, shift,
    output x_out, y_out, exists, game_over, end_shift, snake_head
  );

  modport slave (
    output move_enable, move, grow, shift,
    input  x_out, y_out, exists, game_over, end_shift, snake_head
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: owns segment positions (circular buffer + head pointer),
// direction, length, growth and wall/self collision. On each shift pulse it
// advances one cell, then streams every segment head first, one per cycle,
// followed by a one-cycle end_shift pulse.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : snake_body_engine_if.master (control in, segment stream out)
module snake_body_engine #(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 10,
  parameter int START_Y  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  snake_body_engine_if.master   bus
);
  localparam int X_BITS   = $clog2(H);
  localparam int Y_BITS   = $clog2(V);
  localparam int L_BITS   = $clog2(MAX_LEN + 1);
  localparam int PTR_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef logic [X_BITS+Y_BITS-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  cell_t               body [MAX_LEN];
  logic [PTR_BITS-1:0] head_ptr;
  logic [L_BITS-1:0]   len;
  logic [L_BITS-1:0]   k;            // index of the segment currently driven
  logic [1:0]          dir;
  logic [1:0]          pend;
  logic                grow_pending;
  cell_t               head_q;
  logic [X_BITS-1:0]   x_q;
  logic [Y_BITS-1:0]   y_q;
  logic                exists_q;
  logic                end_q;
  logic                go_q;

  logic [X_BITS-1:0]   head_x;
  logic [Y_BITS-1:0]   head_y;
  logic [X_BITS-1:0]   nx;
  logic [Y_BITS-1:0]   ny;
  logic                hit_wall;
  logic                moving;
  logic [PTR_BITS-1:0] new_ptr;
  logic [L_BITS:0]     rd_sum;
  logic [L_BITS:0]     rd_wrap;
  logic [PTR_BITS-1:0] rd_idx;
  cell_t               seg_next;

  assign head_x = head_q[X_BITS-1:0];
  assign head_y = head_q[X_BITS+Y_BITS-1:X_BITS];

  // Candidate head for the step, using the direction that STEP latches.
  always_comb begin
    nx       = head_x;
    ny       = head_y;
    hit_wall = 1'b0;
    unique case (pend)
      2'd0: if (head_y == '0) hit_wall = 1'b1; else ny = head_y - 1'b1;
      2'd1: if (head_x == X_BITS'(H - 1)) hit_wall = 1'b1; else nx = head_x + 1'b1;
      2'd2: if (head_y == Y_BITS'(V - 1)) hit_wall = 1'b1; else ny = head_y + 1'b1;
      default: if (head_x == '0) hit_wall = 1'b1; else nx = head_x - 1'b1;
    endcase
  end

  assign moving  = !go_q && !hit_wall;
  assign new_ptr = (head_ptr == '0) ? PTR_BITS'(MAX_LEN - 1) : head_ptr - 1'b1;

  // Buffer slot of segment k+1; head_ptr + k + 1 < 2*MAX_LEN so one
  // conditional subtract gives the modulo for any MAX_LEN.
  assign rd_sum   = (L_BITS+1)'(head_ptr) + (L_BITS+1)'(k) + 1'b1;
  assign rd_wrap  = (rd_sum >= (L_BITS+1)'(MAX_LEN)) ? rd_sum - (L_BITS+1)'(MAX_LEN) : rd_sum;
  assign rd_idx   = PTR_BITS'(rd_wrap);
  assign seg_next = body[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      len          <= L_BITS'(INIT_LEN);
      k            <= '0;
      dir          <= 2'd1;
      pend         <= 2'd1;
      grow_pending <= 1'b0;
      head_ptr     <= '0;
      head_q       <= {Y_BITS'(START_Y), X_BITS'(START_X)};
      x_q          <= '0;
      y_q          <= '0;
      exists_q     <= 1'b0;
      end_q        <= 1'b0;
      go_q         <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body[i] <= (i < INIT_LEN) ? {Y_BITS'(START_Y), X_BITS'(START_X - i)} : '0;
      end
    end else begin
      // Reversal is judged against the direction actually being travelled.
      if (bus.move_enable && (bus.move != (dir ^ 2'd2)))
        pend <= bus.move;

      unique case (state)
        IDLE: begin
          if (bus.shift) state <= STEP;
        end

        STEP: begin
          dir      <= pend;
          exists_q <= 1'b1;
          k        <= '0;
          state    <= STREAM;
          if (moving) begin
            head_ptr       <= new_ptr;
            body[new_ptr]  <= {ny, nx};
            head_q         <= {ny, nx};
            x_q            <= nx;
            y_q            <= ny;
            if (grow_pending) begin
              grow_pending <= 1'b0;
              if (len < L_BITS'(MAX_LEN)) len <= len + 1'b1;
            end
          end else begin
            x_q <= head_x;
            y_q <= head_y;
            if (!go_q) go_q <= 1'b1;
          end
        end

        STREAM: begin
          if (k == len - 1'b1) begin
            exists_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            end_q    <= 1'b1;
            state    <= DONE;
          end else begin
            k   <= k + 1'b1;
            x_q <= seg_next[X_BITS-1:0];
            y_q <= seg_next[X_BITS+Y_BITS-1:X_BITS];
            // Flag raised in the same cycle the colliding segment is driven.
            if (seg_next == head_q) go_q <= 1'b1;
          end
        end

        default: begin
          end_q <= 1'b0;
          state <= IDLE;
        end
      endcase

      // A grow pulse arriving in STEP still counts for the following step.
      if (bus.grow) grow_pending <= 1'b1;
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.exists     = exists_q;
  assign bus.end_shift  = end_q;
  assign bus.game_over  = go_q;
  assign bus.snake_head = head_q;
endmodule
